// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-side arbiter that lets N_REQ valid/ready
// producers share one fifo write port. A producer holds the grant for a burst
// of up to MAX_BURST beats. The arbiter never writes while the fifo is full.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_write,
    output logic [WIDTH-1:0]       fifo_data,
    output logic                   grant_valid,
    output logic [IDW-1:0]         grant_id,
    output logic [31:0]            beats_total
);

    // Beat counter wide enough to hold MAX_BURST-1 even when MAX_BURST is 1.
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ - 1);
    localparam logic [IDW:0]   N_REQ_W   = (IDW + 1)'(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q,       state_d;
    logic [IDW-1:0]   ptr_q,         ptr_d;
    logic [CW-1:0]    cnt_q,         cnt_d;
    logic [IDW-1:0]   grant_id_q,    grant_id_d;
    logic             grant_valid_q, grant_valid_d;
    logic [31:0]      beats_total_q, beats_total_d;

    logic [N_REQ-1:0] rot_s;
    logic             arb_found_s;
    logic [IDW-1:0]   arb_off_s;
    logic [IDW:0]     arb_sum_s;
    logic [IDW-1:0]   arb_idx_s;
    logic             sel_valid_s;
    logic [WIDTH-1:0] sel_data_s;

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign beats_total = beats_total_q;

    // Round-robin pick: rotate the request vector so ptr sits at bit 0, take
    // the lowest set bit, then map the offset back to a producer index.
    always_comb begin
        arb_found_s = 1'b0;
        arb_off_s   = '0;
        rot_s       = N_REQ'({req_valid, req_valid} >> ptr_q);
        for (int k = 0; k < N_REQ; k++) begin
            if (!arb_found_s && rot_s[k]) begin
                arb_found_s = 1'b1;
                arb_off_s   = IDW'(k);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        arb_sum_s = {1'b0, ptr_q} + {1'b0, arb_off_s};
        if (arb_sum_s >= N_REQ_W) begin
            arb_idx_s = IDW'(arb_sum_s - N_REQ_W);
        end else begin
            arb_idx_s = IDW'(arb_sum_s);
        end
    end

    // Write-port mux: only the granted producer sees ready, and its word goes
    // straight to the fifo in the same cycle. Reset blocks any handshake.
    always_comb begin
        req_ready   = '0;
        fifo_write  = 1'b0;
        fifo_data   = '0;
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_valid_s = req_valid[i];
                sel_data_s  = req_data[i*WIDTH +: WIDTH];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
        if (!rst && state_q == ST_GRANT) begin
            for (int i = 0; i < N_REQ; i++) begin
                req_ready[i] = (grant_id_q == IDW'(i)) && !fifo_full;
            end
            if (sel_valid_s && !fifo_full) begin
                fifo_write = 1'b1;
                fifo_data  = sel_data_s;
            end else begin
                fifo_write = 1'b0;
                fifo_data  = '0;
            end
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and decide release in GRANT.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        beats_total_d = beats_total_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found_s) begin
                    state_d       = ST_GRANT;
                    grant_id_d    = arb_idx_s;
                    grant_valid_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (fifo_write) begin
                    beats_total_d = beats_total_q + 32'd1;
                    cnt_d         = cnt_q + CW'(1);
                end else begin
                    cnt_d         = cnt_q;
                end
                // A stall (full with valid held) neither writes nor releases.
                if ((fifo_write && cnt_q == LAST_BEAT) || !sel_valid_s) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    cnt_d         = '0;
                    if (grant_id_q == LAST_ID) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_id_q + IDW'(1);
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
                cnt_d         = '0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            beats_total_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            beats_total_q <= beats_total_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle table with hand-computed outputs, then
// stream scenarios against a 16-deep fifo model and per-producer word counters.
module tb_fifo_wr_arbiter;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [31:0]  req_data_a [4];
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic         fifo_write;
    logic [31:0]  fifo_data;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic [31:0]  beats_total;

    logic use_model, tb_full;
    logic model_full = 1'b0;
    logic drain_en;
    int   pop_req_n;
    int   pops_done = 0;
    int   ovf_cnt = 0;
    logic [3:0] acc_r = 4'b0000;
    logic [31:0] fifo_q[$];
    logic [31:0] wr_log[$];
    logic [31:0] rd_log[$];

    int idx [4];
    int n_words [4];
    logic [31:0] base_w [4];

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        full;
        logic [3:0]  ready;
        logic        wr;
        logic [31:0] data;
        logic        gv;
        logic [1:0]  gid;
        logic [31:0] total;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = req_data_a[i];
    end

    assign fifo_full = use_model ? model_full : tb_full;

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
        .fifo_data(fifo_data), .grant_valid(grant_valid), .grant_id(grant_id),
        .beats_total(beats_total)
    );

    // Fifo model plus write/read logs; handshakes recorded for the producers.
    always @(posedge clk) begin
        acc_r <= req_valid & req_ready;
        if ((drain_en || pops_done < pop_req_n) && fifo_q.size() > 0) begin
            rd_log.push_back(fifo_q.pop_front());
            if (!drain_en) pops_done <= pops_done + 1;
        end
        if (fifo_write) begin
            if (use_model && fifo_full) ovf_cnt <= ovf_cnt + 1;
            fifo_q.push_back(fifo_data);
            wr_log.push_back(fifo_data);
        end
        model_full <= (fifo_q.size() >= DEPTH);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(int k);
        if (k < wr_log.size()) return wr_log[k];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rd_at(int k);
        if (k < rd_log.size()) return rd_log[k];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            idx[i] = 0;
            n_words[i] = 0;
            base_w[i] = 32'h0;
            req_data_a[i] = 32'h0;
        end
        @(negedge clk);
        rst = 1'b0;
        wr_log.delete();
        rd_log.delete();
        fifo_q.delete();
    endtask

    // Advance each producer past an accepted word and present the next one.
    task automatic stream_step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (acc_r[i]) idx[i]++;
            req_valid[i] = (idx[i] < n_words[i]);
            req_data_a[i] = base_w[i] + 32'(idx[i]);
        end
        #1;
    endtask

    initial begin
        int errs, c0, c1, steps, p, kk;
        logic [31:0] w, e;
        rst = 1'b1;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) req_data_a[i] = 32'h0;
        use_model = 1'b0;
        tb_full = 1'b0;
        drain_en = 1'b0;
        pop_req_n = 0;

        //          rst   valid    full  ready    wr    data           gv    gid   total
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 2'd0, 32'd0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 2'd0, 32'd0};
        tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'hCAFE_0000, 1'b1, 2'd0, 32'd0};
        tbl[3]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 32'h0,         1'b1, 2'd0, 32'd1};
        tbl[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'hCAFE_0000, 1'b1, 2'd0, 32'd1};
        tbl[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'hCAFE_0000, 1'b1, 2'd0, 32'd2};
        tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'hCAFE_0000, 1'b1, 2'd0, 32'd3};
        tbl[7]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 2'd0, 32'd4};
        tbl[8]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 32'hCAFE_0000, 1'b1, 2'd0, 32'd4};
        tbl[9]  = '{1'b0, 4'b0010, 1'b0, 4'b0001, 1'b0, 32'h0,         1'b1, 2'd0, 32'd5};
        tbl[10] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 2'd0, 32'd5};
        tbl[11] = '{1'b0, 4'b1010, 1'b1, 4'b0000, 1'b0, 32'h0,         1'b1, 2'd1, 32'd5};
        tbl[12] = '{1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 32'h0,         1'b1, 2'd1, 32'd5};
        tbl[13] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 2'd0, 32'd5};
        tbl[14] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 32'hCAFE_0003, 1'b1, 2'd3, 32'd5};
        tbl[15] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 2'd3, 32'd6};
        tbl[16] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 2'd0, 32'd0};
        tbl[17] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 32'hCAFE_0003, 1'b1, 2'd3, 32'd0};

        repeat (2) @(negedge clk);

        // Cycle table: inputs applied on the falling edge, outputs checked 1 time unit later.
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            rst = tbl[j].rst;
            req_valid = tbl[j].valid;
            tb_full = tbl[j].full;
            for (int i = 0; i < 4; i++) req_data_a[i] = 32'hCAFE_0000 + 32'(i);
            #1;
            check($sformatf("v%0d_ready", j), {28'h0, req_ready}, {28'h0, tbl[j].ready});
            check($sformatf("v%0d_write", j), {31'h0, fifo_write}, {31'h0, tbl[j].wr});
            check($sformatf("v%0d_data", j), fifo_data, tbl[j].data);
            check($sformatf("v%0d_gvalid", j), {31'h0, grant_valid}, {31'h0, tbl[j].gv});
            check($sformatf("v%0d_gid", j), {30'h0, grant_id}, {30'h0, tbl[j].gid});
            check($sformatf("v%0d_total", j), beats_total, tbl[j].total);
        end

        use_model = 1'b1;

        // Single producer, three words, grant one cycle after valid.
        do_reset();
        n_words[0] = 3; base_w[0] = 32'h10;
        stream_step();
        check("t1_no_grant_first_cycle", {31'h0, grant_valid}, 32'd0);
        check("t1_no_write_first_cycle", {31'h0, fifo_write}, 32'd0);
        stream_step();
        check("t1_grant_valid", {31'h0, grant_valid}, 32'd1);
        check("t1_grant_id", {30'h0, grant_id}, 32'd0);
        check("t1_first_data", fifo_data, 32'h10);
        repeat (8) stream_step();
        check("t1_count", 32'(wr_log.size()), 32'd3);
        for (int k = 0; k < 3; k++) check($sformatf("t1_word%0d", k), wr_at(k), 32'h10 + 32'(k));
        check("t1_total", beats_total, 32'd3);

        // Four producers, eight words each, fifo drained every cycle.
        do_reset();
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_words[i] = 8; base_w[i] = 32'(i) * 32'h100;
        end
        steps = 0;
        while (rd_log.size() < 32 && steps < 400) begin
            stream_step();
            steps++;
        end
        check("t2_read_count", 32'(rd_log.size()), 32'd32);
        for (int m = 0; m < 32; m++) begin
            p = (m % 16) / 4;
            kk = (m / 16) * 4 + (m % 4);
            check($sformatf("t2_order%0d", m), rd_at(m), 32'(p) * 32'h100 + 32'(kk));
        end
        check("t2_total", beats_total, 32'd32);
        drain_en = 1'b0;

        // No drain: fifo fills at 16, one read lets word 17 through.
        do_reset();
        n_words[2] = 20; base_w[2] = 32'h2000;
        repeat (60) stream_step();
        check("t3_full", {31'h0, fifo_full}, 32'd1);
        check("t3_ready_low_full", {31'h0, req_ready[2]}, 32'd0);
        check("t3_write_low_full", {31'h0, fifo_write}, 32'd0);
        check("t3_written_16", 32'(wr_log.size()), 32'd16);
        check("t3_total_16", beats_total, 32'd16);
        pop_req_n = pops_done + 1;
        repeat (10) stream_step();
        check("t3_written_17", 32'(wr_log.size()), 32'd17);
        check("t3_word17", wr_at(16), 32'h2010);
        check("t3_read_word", rd_at(0), 32'h2000);
        check("t3_no_overflow", 32'(ovf_cnt), 32'd0);

        // r3 alone, then r0 and r3 together: pointer wraps to 0, r0 wins.
        do_reset();
        n_words[3] = 1; base_w[3] = 32'h3000;
        repeat (6) stream_step();
        n_words[0] = 1; base_w[0] = 32'h0A00; n_words[3] = 2;
        stream_step();
        stream_step();
        check("t4_second_grant_id", {30'h0, grant_id}, 32'd0);
        repeat (10) stream_step();
        check("t4_count", 32'(wr_log.size()), 32'd3);
        check("t4_first", wr_at(0), 32'h3000);
        check("t4_second", wr_at(1), 32'h0A00);
        check("t4_third", wr_at(2), 32'h3001);

        // Reset on the second beat of an r1 burst.
        do_reset();
        n_words[1] = 4; base_w[1] = 32'h5000;
        stream_step();
        stream_step();
        check("t5_beat1_write", {31'h0, fifo_write}, 32'd1);
        check("t5_beat1_data", fifo_data, 32'h5000);
        stream_step();
        rst = 1'b1;
        #1;
        check("t5_rst_write", {31'h0, fifo_write}, 32'd0);
        check("t5_rst_ready", {28'h0, req_ready}, 32'd0);
        stream_step();
        rst = 1'b0;
        #1;
        check("t5_after_gvalid", {31'h0, grant_valid}, 32'd0);
        check("t5_after_gid", {30'h0, grant_id}, 32'd0);
        check("t5_after_total", beats_total, 32'd0);
        repeat (10) stream_step();
        check("t5_count", 32'(wr_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t5_word%0d", k), wr_at(k), 32'h5000 + 32'(k));
        check("t5_total", beats_total, 32'd3);

        // Two long streams with concurrent draining.
        do_reset();
        drain_en = 1'b1;
        n_words[0] = 80; base_w[0] = 32'h6000_0000;
        n_words[1] = 80; base_w[1] = 32'h6100_0000;
        steps = 0;
        while (rd_log.size() < 160 && steps < 1500) begin
            stream_step();
            steps++;
        end
        errs = 0; c0 = 0; c1 = 0;
        for (int m = 0; m < rd_log.size(); m++) begin
            w = rd_log[m];
            if (w[31:24] == 8'h60) begin
                e = 32'h6000_0000 + 32'(c0); c0++;
            end else begin
                e = 32'h6100_0000 + 32'(c1); c1++;
            end
            if (w !== e) errs++;
        end
        check("t6_read_count", 32'(rd_log.size()), 32'd160);
        check("t6_r0_count", 32'(c0), 32'd80);
        check("t6_r1_count", 32'(c1), 32'd80);
        check("t6_order_errors", 32'(errs), 32'd0);
        check("t6_total", beats_total, 32'd160);
        check("t6_no_overflow", 32'(ovf_cnt), 32'd0);
        drain_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
